// File: rtl/xgmii_frame_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | xgmii_frame_gen : XGMII Ethernet test-frame burst generator with CRC-32 FCS  |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
module xgmii_frame_gen #(
    parameter int IFG_WORDS = 2,
    parameter int MAX_LEN   = 1518
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [10:0] frame_len,
    input  logic [15:0] frame_count,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [15:0] ethertype,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    output logic        busy,
    output logic        done,
    output logic [31:0] tx_frames
);

    localparam logic [63:0] c_IDLE_TXD = 64'h0707070707070707;
    localparam logic [63:0] c_SOF_TXD  = 64'hD5555555555555FB;
    localparam logic [10:0] c_MAX_LEN  = 11'(MAX_LEN);
    localparam logic [15:0] c_IFG      = 16'(IFG_WORDS);

    typedef enum logic [2:0] {IDLE, SOF, DATA, TERM, IFG} state_t;

    state_t       r_state, w_state;
    logic [10:0]  r_len;
    logic [15:0]  r_count, r_sent, r_ifg, w_ifg;
    logic [47:0]  r_da, r_sa;
    logic [15:0]  r_type;
    logic         r_stop;
    logic [11:0]  r_off, w_off;
    logic [31:0]  r_crc, w_crc;
    logic [63:0]  w_txd;
    logic [7:0]   w_txc;
    logic         w_busy, w_done, w_term, w_load, w_end;
    logic [10:0]  w_len_clamped;

    logic [11:0]  w_full_end, w_fcs_start;
    logic         w_is_term;
    logic [3:0]   w_lanes;
    logic [111:0] w_hdr;
    logic [63:0]  w_word_txd;
    logic [7:0]   w_word_txc;
    logic [31:0]  w_word_crc;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    assign w_len_clamped = (frame_len < 11'd64)    ? 11'd64 :
                           (frame_len > c_MAX_LEN) ? c_MAX_LEN : frame_len;

    // Builds the frame word starting at byte r_off; the CRC is folded lane by
    // lane so FCS bytes sharing a word with the last payload bytes are exact.
    always_comb begin
        logic [11:0] b;
        logic [7:0]  byt;
        logic [3:0]  hb;
        logic [31:0] fcs;
        w_full_end  = {1'b0, r_len[10:3], 3'b000};
        w_fcs_start = {1'b0, r_len} - 12'd4;
        w_is_term   = (r_off >= w_full_end);
        w_lanes     = w_is_term ? {1'b0, r_len[2:0]} : 4'd8;
        w_hdr       = {r_da, r_sa, r_type};
        w_word_crc  = r_crc;
        w_word_txd  = '0;
        w_word_txc  = '0;
        for (int i = 0; i < 8; i++) begin
            b   = r_off + 12'(i);
            hb  = 4'd13 - b[3:0];
            fcs = ~w_word_crc;
            byt = 8'(b - 12'd14);
            if (b < 12'd14)
                byt = w_hdr[{hb, 3'b000} +: 8];
            else if (b >= w_fcs_start)
                byt = fcs[{b[1:0] - w_fcs_start[1:0], 3'b000} +: 8];
            if (4'(i) < w_lanes) begin
                w_word_txd[8*i +: 8] = byt;
                if (b < w_fcs_start)
                    w_word_crc = crc32_byte(w_word_crc, byt);
            end else begin
                w_word_txc[i]        = 1'b1;
                w_word_txd[8*i +: 8] = (4'(i) == w_lanes) ? 8'hFD : 8'h07;
            end
        end
    end

    always_comb begin
        w_state = r_state;
        w_txd   = c_IDLE_TXD;
        w_txc   = 8'hFF;
        w_off   = r_off;
        w_crc   = r_crc;
        w_ifg   = r_ifg;
        w_busy  = busy;
        w_done  = 1'b0;
        w_term  = 1'b0;
        w_load  = 1'b0;
        w_end   = r_stop | stop | ((r_count != 16'd0) && (r_sent == r_count));
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load  = 1'b1;
                    w_busy  = 1'b1;
                    w_state = SOF;
                    w_txd   = c_SOF_TXD;
                    w_txc   = 8'h01;
                    w_off   = '0;
                    w_crc   = '1;
                end
            end
            SOF, DATA: begin
                w_txd = w_word_txd;
                w_txc = w_word_txc;
                w_crc = w_word_crc;
                if (w_is_term) begin
                    w_state = TERM;
                    w_term  = 1'b1;
                end else begin
                    w_state = DATA;
                    w_off   = r_off + 12'd8;
                end
            end
            TERM, IFG: begin
                if (r_state == TERM && c_IFG != 16'd0) begin
                    w_state = IFG;
                    w_ifg   = 16'd1;
                end else if (r_state == IFG && r_ifg < c_IFG) begin
                    w_ifg = r_ifg + 16'd1;
                end else if (w_end) begin
                    w_state = IDLE;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end else begin
                    w_state = SOF;
                    w_txd   = c_SOF_TXD;
                    w_txc   = 8'h01;
                    w_off   = '0;
                    w_crc   = '1;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= IDLE;
            xgmii_txd <= c_IDLE_TXD;
            xgmii_txc <= 8'hFF;
            busy      <= 1'b0;
            done      <= 1'b0;
            tx_frames <= '0;
            r_off     <= '0;
            r_crc     <= '0;
            r_ifg     <= '0;
            r_sent    <= '0;
            r_stop    <= 1'b0;
            r_len     <= '0;
            r_count   <= '0;
            r_da      <= '0;
            r_sa      <= '0;
            r_type    <= '0;
        end else begin
            r_state   <= w_state;
            xgmii_txd <= w_txd;
            xgmii_txc <= w_txc;
            busy      <= w_busy;
            done      <= w_done;
            r_off     <= w_off;
            r_crc     <= w_crc;
            r_ifg     <= w_ifg;
            if (w_term) begin
                tx_frames <= tx_frames + 32'd1;
                r_sent    <= r_sent + 16'd1;
            end
            if (w_load) begin
                r_len   <= w_len_clamped;
                r_count <= frame_count;
                r_da    <= dst_mac;
                r_sa    <= src_mac;
                r_type  <= ethertype;
                r_sent  <= '0;
                r_stop  <= stop;
            end else if (busy && stop) begin
                r_stop <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xgmii_frame_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_xgmii_frame_gen : directed self-checking bench for xgmii_frame_gen        |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
module tb_xgmii_frame_gen;

    localparam int          IFG    = 2;
    localparam logic [63:0] IDLE_D = 64'h0707070707070707;
    localparam logic [63:0] SOF_D  = 64'hD5555555555555FB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop;
    logic [10:0] frame_len;
    logic [15:0] frame_count;
    logic [47:0] dst_mac, src_mac;
    logic [15:0] ethertype;
    logic [63:0] txd;
    logic [7:0]  txc;
    logic        busy, done;
    logic [31:0] tx_frames;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;
    int cyc = 0;
    int t_sof;
    logic [7:0] exp_b [0:2047];
    logic [7:0] got_b [0:2047];

    xgmii_frame_gen #(.IFG_WORDS(IFG), .MAX_LEN(1518)) dut (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .start      (start),
        .stop       (stop),
        .frame_len  (frame_len),
        .frame_count(frame_count),
        .dst_mac    (dst_mac),
        .src_mac    (src_mac),
        .ethertype  (ethertype),
        .xgmii_txd  (txd),
        .xgmii_txc  (txc),
        .busy       (busy),
        .done       (done),
        .tx_frames  (tx_frames)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // Expected frame bytes from the current input config.
    task automatic build(input int len);
        logic [31:0]  c;
        logic [111:0] hdr;
        hdr = {dst_mac, src_mac, ethertype};
        c = 32'hFFFFFFFF;
        for (int b = 0; b < len - 4; b++) begin
            if (b < 14) exp_b[b] = hdr[111 - 8*b -: 8];
            else        exp_b[b] = 8'(b - 14);
            c = crc_byte(c, exp_b[b]);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp_b[len - 4 + k] = c[8*k +: 8];
    endtask

    function automatic logic [63:0] exp_word(input int i);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = exp_b[8*i + k];
        return w;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Entered with the SOF word on the outputs; leaves after the last IFG word.
    task automatic check_frame(input int len, input int stop_word);
        logic [63:0] et;
        logic [7:0]  ec;
        int r;
        chk("sof_txd", txd, SOF_D);
        chk("sof_txc", 64'(txc), 64'h01);
        chk("sof_busy", 64'(busy), 64'h1);
        for (int i = 0; i < len / 8; i++) begin
            if (i == stop_word) stop = 1'b1;
            tick();
            chk("data_txd", txd, exp_word(i));
            chk("data_txc", 64'(txc), 64'h00);
            for (int k = 0; k < 8; k++) got_b[8*i + k] = txd[8*k +: 8];
        end
        tick();
        r = len % 8;
        for (int k = 0; k < 8; k++) begin
            if (k < r) begin
                et[8*k +: 8] = exp_b[8*(len/8) + k];
                got_b[8*(len/8) + k] = txd[8*k +: 8];
            end else if (k == r) et[8*k +: 8] = 8'hFD;
            else                 et[8*k +: 8] = 8'h07;
        end
        ec = 8'hFF << r;
        chk("term_txd", txd, et);
        chk("term_txc", 64'(txc), 64'(ec));
        exp_frames++;
        chk("tx_frames_at_term", 64'(tx_frames), 64'(exp_frames));
        for (int k = 0; k < IFG; k++) begin
            tick();
            chk("ifg_txd", txd, IDLE_D);
            chk("ifg_busy", 64'(busy), 64'h1);
        end
    endtask

    task automatic check_done();
        tick();
        chk("done_pulse", 64'(done), 64'h1);
        chk("done_busy", 64'(busy), 64'h0);
        chk("done_txd", txd, IDLE_D);
        chk("done_tx_frames", 64'(tx_frames), 64'(exp_frames));
        tick();
        chk("done_one_cycle", 64'(done), 64'h0);
    endtask

    initial begin
        logic [31:0] c, rev;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        frame_len = 11'd64; frame_count = 16'd1;
        dst_mac = 48'hFFFFFFFFFFFF; src_mac = 48'h001122334455; ethertype = 16'h0800;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", txd, IDLE_D);
        chk("rst_txc", 64'(txc), 64'hFF);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_tx_frames", 64'(tx_frames), 64'h0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", txd, IDLE_D);

        // Minimum frame, broadcast DA, single frame burst.
        build(64);
        pulse_start();
        check_frame(64, -1);
        check_done();

        // L=65 with config changed after start; residue over the emitted frame.
        frame_len = 11'd65; dst_mac = 48'h0123456789AB; src_mac = 48'hA0B1C2D3E4F5;
        ethertype = 16'h88B5; frame_count = 16'd1;
        build(65);
        pulse_start();
        frame_len = 11'd200; dst_mac = '0; ethertype = '0; frame_count = 16'd3;
        check_frame(65, -1);
        c = 32'hFFFFFFFF;
        for (int b = 0; b < 65; b++) c = crc_byte(c, got_b[b]);
        for (int k = 0; k < 32; k++) rev[k] = c[31 - k];
        chk("crc_residue", 64'(rev), 64'hC704DD7B);
        check_done();

        // Length clamps.
        frame_len = 11'd10; frame_count = 16'd1;
        build(64);
        pulse_start();
        check_frame(64, -1);
        check_done();
        frame_len = 11'd2000;
        build(1518);
        pulse_start();
        check_frame(1518, -1);
        check_done();

        // Continuous burst with stop raised in frame 3.
        frame_len = 11'd64; frame_count = 16'd0;
        build(64);
        pulse_start();
        t_sof = cyc;
        check_frame(64, -1);
        tick();
        chk("sof_gap", 64'(cyc - t_sof - 1), 64'd11);
        check_frame(64, -1);
        tick();
        check_frame(64, 3);
        stop = 1'b0;
        check_done();

        // start and stop together: exactly one frame.
        frame_count = 16'd0;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check_frame(64, -1);
        check_done();

        // Reset during frame 2 of a 5-frame burst; restart attempt ignored while busy.
        frame_count = 16'd5;
        pulse_start();
        check_frame(64, -1);
        tick();
        chk("f2_sof", txd, SOF_D);
        tick();
        chk("f2_word0", txd, exp_word(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("f2_restart_ignored", txd, exp_word(1));
        chk("f2_busy", 64'(busy), 64'h1);
        rst_n = 1'b0;
        #1;
        exp_frames = 0;
        chk("mid_rst_txd", txd, IDLE_D);
        chk("mid_rst_txc", 64'(txc), 64'hFF);
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_tx_frames", 64'(tx_frames), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_txd", txd, IDLE_D);
        repeat (4) tick();
        chk("no_autostart_txd", txd, IDLE_D);
        chk("no_autostart_busy", 64'(busy), 64'h0);
        chk("no_autostart_done", 64'(done), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
